comms_rx_buffer: RTL

Receive-side buffer of the communications processor that fills the words the general-purpose processor reads. Packets arrive from the network as 16-bit word beats and are written into a two-bank ping-pong RAM. When a bank holds a complete packet, the block presents it to the GPP datapath through `RAM_rx_data_out` and `data_rx_flag`. The GPP releases the bank with an acknowledge, so network fill and GPP drain overlap.

---
 rtl/comms_pkg.sv | 13 +
 rtl/comms_rx_bank_ram.sv | 38 +++
 rtl/comms_rx_buffer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/comms_pkg.sv
// Shared types and default sizes for the communications receive buffer.
package comms_pkg;

  localparam int COMMS_DATA_W     = 16;
  localparam int COMMS_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } bank_state_t;

endpackage

// File: rtl/comms_rx_bank_ram.sv
// Two-bank packet word store: one synchronous write port and one registered
// read port, both addressed as {bank, word}.
module comms_rx_bank_ram import comms_pkg::*; #(
  parameter int DEPTH_LOG2 = COMMS_DEPTH_LOG2,
  parameter int DATA_W     = COMMS_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [DEPTH_LOG2:0] wr_idx_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DEPTH_LOG2:0] rd_idx_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  localparam int WORDS = 2 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rd_data_q;

  // Storage carries no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/comms_rx_buffer.sv
// Ping-pong receive buffer between network beats and the GPP read datapath.
// Define COMMS_RX_OVERFLOW_DROP_EN to discard overflowing packets instead of truncating them.
module comms_rx_buffer import comms_pkg::*; #(
  parameter int DEPTH_LOG2 = COMMS_DEPTH_LOG2,
  parameter int DATA_W     = COMMS_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  net_valid,
  input  logic [DATA_W-1:0]     net_data,
  input  logic                  net_last,
  output logic                  net_ready,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  input  logic                  rx_ack,
  output logic [DATA_W-1:0]     RAM_rx_data_out,
  output logic                  data_rx_flag,
  output logic [DEPTH_LOG2:0]   rx_length,
  output logic                  rx_overflow
);

  localparam logic [DEPTH_LOG2:0] ZERO_CNT = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  bank_state_t             bank_q [2];
  bank_state_t             bank_d [2];
  logic [DEPTH_LOG2:0]     len_q  [2];
  logic [DEPTH_LOG2:0]     len_d  [2];
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [DEPTH_LOG2:0]     cnt_q, cnt_d;

  logic                    net_ready_q, net_ready_d;
  logic                    flag_q, flag_d;
  logic [DEPTH_LOG2:0]     rx_length_q, rx_length_d;
  logic                    rx_overflow_q, rx_overflow_d;

  logic                    accept_s;
  logic                    ovf_beat_s;
  logic                    ack_s;
  logic                    wr_en_s;
  logic [DEPTH_LOG2:0]     wr_idx_s;
  logic [DEPTH_LOG2:0]     rd_idx_s;

  // The counter saturates at full, so a beat arriving there lies past bank capacity.
  assign accept_s   = net_valid && net_ready_q;
  assign ovf_beat_s = accept_s && (cnt_q == FULL_CNT);
  assign ack_s      = rx_ack && flag_q;
  assign wr_en_s    = accept_s && !ovf_beat_s;
  assign wr_idx_s   = {wr_bank_q, cnt_q[DEPTH_LOG2-1:0]};
  assign rd_idx_s   = {rd_bank_q, rd_addr};

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      len_q[0]  <= ZERO_CNT;
      len_q[1]  <= ZERO_CNT;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      cnt_q     <= ZERO_CNT;
    end else begin
      bank_q    <= bank_d;
      len_q     <= len_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      cnt_q     <= cnt_d;
    end
  end

  // Fill and drain touch different banks whenever both fire on one edge.
  always_comb begin
    bank_d    = bank_q;
    len_d     = len_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    cnt_d     = cnt_q;
    if (accept_s && net_last) begin
      cnt_d = ZERO_CNT;
`ifdef COMMS_RX_OVERFLOW_DROP_EN
      if (ovf_beat_s) begin
        bank_d[wr_bank_q] = EMPTY;
      end else begin
        bank_d[wr_bank_q] = READY;
        len_d[wr_bank_q]  = cnt_q + ONE_CNT;
        wr_bank_d         = ~wr_bank_q;
      end
`else
      bank_d[wr_bank_q] = READY;
      len_d[wr_bank_q]  = ovf_beat_s ? FULL_CNT : (cnt_q + ONE_CNT);
      wr_bank_d         = ~wr_bank_q;
`endif
    end else if (accept_s) begin
      bank_d[wr_bank_q] = FILLING;
      cnt_d             = ovf_beat_s ? FULL_CNT : (cnt_q + ONE_CNT);
    end else begin
      cnt_d = cnt_q;
    end
    if (ack_s) begin
      bank_d[rd_bank_q] = EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  always_comb begin
    flag_d        = (bank_d[rd_bank_d] == READY);
    net_ready_d   = (bank_d[wr_bank_d] != READY);
    rx_overflow_d = rx_overflow_q || ovf_beat_s;
    if (flag_d) begin
      rx_length_d = len_d[rd_bank_d];
    end else begin
      rx_length_d = ZERO_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      net_ready_q   <= 1'b1;
      flag_q        <= 1'b0;
      rx_length_q   <= ZERO_CNT;
      rx_overflow_q <= 1'b0;
    end else begin
      net_ready_q   <= net_ready_d;
      flag_q        <= flag_d;
      rx_length_q   <= rx_length_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  comms_rx_bank_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_s),
    .wr_idx_i  (wr_idx_s),
    .wr_data_i (net_data),
    .rd_idx_i  (rd_idx_s),
    .rd_data_o (RAM_rx_data_out)
  );

  assign net_ready    = net_ready_q;
  assign data_rx_flag = flag_q;
  assign rx_length    = rx_length_q;
  assign rx_overflow  = rx_overflow_q;

endmodule
